// File: rtl/alu_pkg.sv
// Shared opcode constants and types for the sequential ALU.
// Used by alu_seq and its timer sub-block.
package alu_pkg;

    localparam int MODE_BIT = 5;

    localparam logic [1:0] GRP_ALU = 2'b00;
    localparam logic [1:0] GRP_TMR = 2'b01;

    localparam logic [2:0] OP_LOAD = 3'b000;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NADD = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_EQ    = 3'b000,
        CMP_NE    = 3'b001,
        CMP_LT    = 3'b010,
        CMP_LE    = 3'b011,
        CMP_GT    = 3'b100,
        CMP_GE    = 3'b101,
        CMP_TMR   = 3'b110,
        CMP_NEVER = 3'b111
    } cmp_op_e;

    typedef struct packed {
        logic skip;
        logic carry;
        logic zero;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU.
// master drives requests, slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic [7:0]         dir;
    logic [WIDTH-1:0]   data_a;
    logic [WIDTH-1:0]   data_b;
    logic [WIDTH-1:0]   address;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;
    logic               skip;
    logic               carry;
    logic               zero;
    logic               illegal;
    logic               delay;
    logic [3*WIDTH-1:0] delay_data;
    logic               delay_done;

    modport master (
        output dir, data_a, data_b, address, in_valid, out_ready,
        input  in_ready, out_valid, out, skip, carry, zero, illegal,
        input  delay, delay_data, delay_done
    );

    modport slave (
        input  dir, data_a, data_b, address, in_valid, out_ready,
        output in_ready, out_valid, out, skip, carry, zero, illegal,
        output delay, delay_data, delay_done
    );
endinterface

// File: rtl/alu_timer.sv
// Down-counting delay timer; load wins over decrement.
// done pulses one cycle when the count steps 1 -> 0.
module alu_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done
);

    assign busy = |count;

    // count down while nonzero, reload restarts without a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            done  <= 1'b0;
        end else if (busy) begin
            count <= count - 1'b1;
            done  <= (count == W'(1));
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// One-cycle sequential ALU with compare/skip mode and optional timer.
// Timer present only when ALU_SEQ_TIMER_EN is defined.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);

    localparam int SW = $clog2(WIDTH);

    logic             accept;
    logic             mode;
    logic [1:0]       grp;
    logic [2:0]       op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [SW-1:0]    shamt;
    logic             tmr_nz;
    logic [WIDTH-1:0] res;
    alu_flags_t       flg;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    alu_flags_t       flg_q;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    assign mode  = bus.dir[MODE_BIT];
    assign grp   = bus.dir[4:3];
    assign op    = bus.dir[2:0];
    assign sum   = {1'b0, bus.data_a} + {1'b0, bus.data_b};
    assign diff  = bus.data_a - bus.data_b;
    assign shamt = bus.data_b[SW-1:0];

`ifdef ALU_SEQ_TIMER_EN
    localparam int TW = 3 * WIDTH;

    logic          ld_req;
    logic [TW-1:0] tcount;
    logic          tbusy;
    logic          tdone;

    alu_timer #(
        .W(TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && ld_req),
        .load_value ({bus.data_a, bus.data_b, bus.address}),
        .count      (tcount),
        .busy       (tbusy),
        .done       (tdone)
    );

    assign tmr_nz         = tbusy;
    assign bus.delay      = tbusy;
    assign bus.delay_data = tcount;
    assign bus.delay_done = tdone;
`else
    assign tmr_nz         = 1'b0;
    assign bus.delay      = 1'b0;
    assign bus.delay_data = '0;
    assign bus.delay_done = 1'b0;
`endif

    // decode opcode into result, flags and timer load request
    always_comb begin
        res = '0;
        flg = '0;
`ifdef ALU_SEQ_TIMER_EN
        ld_req = 1'b0;
`endif
        if (mode) begin
            unique case (cmp_op_e'(op))
                CMP_EQ:    flg.skip = (bus.data_a == bus.data_b);
                CMP_NE:    flg.skip = (bus.data_a != bus.data_b);
                CMP_LT:    flg.skip = (bus.data_a <  bus.data_b);
                CMP_LE:    flg.skip = (bus.data_a <= bus.data_b);
                CMP_GT:    flg.skip = (bus.data_a >  bus.data_b);
                CMP_GE:    flg.skip = (bus.data_a >= bus.data_b);
                CMP_TMR:   flg.skip = tmr_nz;
                CMP_NEVER: flg.skip = 1'b0;
            endcase
        end else begin
            unique case (grp)
                GRP_ALU: begin
                    unique case (alu_op_e'(op))
                        OP_ADD: begin
                            res       = sum[WIDTH-1:0];
                            flg.carry = sum[WIDTH];
                        end
                        OP_SUB: begin
                            res       = diff;
                            flg.carry = (bus.data_a < bus.data_b);
                        end
                        OP_AND:  res = bus.data_a & bus.data_b;
                        OP_OR:   res = bus.data_a | bus.data_b;
                        OP_NADD: res = ~sum[WIDTH-1:0];
                        OP_XOR:  res = bus.data_a ^ bus.data_b;
                        OP_SHL:  res = bus.data_a << shamt;
                        OP_SHR:  res = bus.data_a >> shamt;
                    endcase
                end
                GRP_TMR: begin
`ifdef ALU_SEQ_TIMER_EN
                    if (op == OP_LOAD) begin
                        ld_req = 1'b1;
                    end else begin
                        flg.illegal = 1'b1;
                    end
`else
                    flg.illegal = 1'b1;
`endif
                end
                default: flg.illegal = 1'b1;
            endcase
        end
        flg.zero = (res == '0);
    end

    // result register: capture on accept, drop valid on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flg_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= res;
            flg_q       <= flg;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.skip      = flg_q.skip;
    assign bus.carry     = flg_q.carry;
    assign bus.zero      = flg_q.zero;
    assign bus.illegal   = flg_q.illegal;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal range 4..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dir  input  8  opcode: bit5 compare mode, bits4:3 group, bits2:0 op.
REQ-005 SHALL have ports data_a, data_b, address  input  WIDTH  operands.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1 as the request handshake.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1 as the response handshake.
REQ-008 SHALL have port out  output  WIDTH  registered result.
REQ-009 SHALL have ports skip, carry, zero, illegal  output  1  registered flags, qualified by out_valid.
REQ-010 SHALL have ports delay output 1 (timer nonzero), delay_data output 3*WIDTH (timer value), delay_done output 1 (one-cycle pulse on timer reaching zero).

Function
REQ-011 Request SHALL be accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-012 Latency SHALL be one cycle: accepted request produces out_valid on the next edge; output registers hold while out_valid && !out_ready.
REQ-013 out_valid SHALL clear on out_ready with no new accept; simultaneous drain and accept SHALL keep out_valid high with new data.
REQ-014 dir[5]=0, group 00 SHALL compute: 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 ~(a+b), 101 a^b, 110 a<<b[log2(WIDTH)-1:0], 111 a>>b[log2(WIDTH)-1:0]; skip=0.
REQ-015 carry SHALL be carry-out of add, borrow (a<b) of sub, 0 otherwise; all arithmetic modulo 2^WIDTH.
REQ-016 zero SHALL be 1 when out==0.
REQ-017 dir[5]=0, group 01, op 000 SHALL load timer with {data_a,data_b,address}; out=0, skip=0.
REQ-018 dir[5]=0 with group 10/11, or group 01 op!=000, SHALL give out=0, skip=0, illegal=1; no state change.
REQ-019 dir[5]=1 SHALL set skip: 000 a==b, 001 a!=b, 010 a<b, 011 a<=b, 100 a>b, 101 a>=b, 110 timer!=0 (sampled at accept), 111 0; out=0, unsigned compares.
REQ-020 Timer SHALL decrement by 1 each cycle while nonzero, independent of handshake stalls.
REQ-021 Load SHALL take priority over decrement in the same cycle; load of 0 leaves timer idle with no delay_done pulse.
REQ-022 delay_done SHALL pulse for exactly one cycle on the edge timer goes 1 -> 0; reload while nonzero SHALL restart count without pulse.
REQ-023 delay SHALL equal (delay_data != 0) combinationally from the timer register.

Reset
REQ-024 On rst_n low, out_valid, out, skip, carry, zero, illegal, delay_done, timer SHALL clear to 0 immediately; in_ready SHALL read 1.
REQ-025 Reset mid-countdown or mid-stall SHALL discard the pending result and timer value.

Configuration
REQ-026 With ALU_SEQ_TIMER_EN defined, timer behaviour REQ-017, REQ-020..023 SHALL be present.
REQ-027 Without ALU_SEQ_TIMER_EN, timer logic SHALL be absent: load op SHALL set illegal=1, compare op 110 SHALL give skip=0, delay/delay_data/delay_done SHALL tie to 0.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode group/op constants, mode bit index and compare-op enumeration.
REQ-029 Timer SHALL be a sub-module alu_timer (parameter W=3*WIDTH; load, load_value, count, busy, done).

Verification
REQ-030 WIDTH=8: add 200+100 -> out=44, carry=1, zero=0 one cycle after accept.
REQ-031 sub 5-5 -> out=0, zero=1, carry=0; sub 3-7 -> out=252, carry=1.
REQ-032 Compare dir=0x22 (a<b), a=3,b=9 -> skip=1, out=0; dir=0x20 a=9,b=9 -> skip=1.
REQ-033 Load timer {0,0,3} -> delay=1 for 3 cycles, delay_done pulse on 3rd, skip-op 110 issued after -> skip=0.
REQ-034 Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out stable; release -> back-to-back results one per cycle.
REQ-035 dir=0x10|0x08 (group 11) -> illegal=1, out=0; assert rst_n low mid-countdown -> all outputs 0 asynchronously.
